// File: rtl/final_adder_ms.sv
// Digit-serial carry-save resolver with optional modular reduction.
// Reduction (diff path, borrow chain, select mux) is built when FINAL_ADDER_REDUCE_EN is defined.
module final_adder_ms #(
    parameter int DATA_WIDTH  = 32,
    parameter int DIGIT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  start_final_addition,
    input  logic [DATA_WIDTH-1:0] s0_r,
    input  logic [DATA_WIDTH-1:0] s1_r,
    input  logic [DATA_WIDTH-1:0] n,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] m,
    output logic                  cout
);

    localparam int NUM_DIGITS = DATA_WIDTH / DIGIT_WIDTH;
    localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    if (DATA_WIDTH % DIGIT_WIDTH != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of DIGIT_WIDTH");
    end

    typedef enum logic [1:0] {IDLE, ADD, SEL} state_t;

    state_t                state, state_nx;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] s0_q, s1_q, sum_q, result;
    logic                  carry;
    logic [DIGIT_WIDTH:0]  sum_d;
    logic                  accept, last;

    assign accept = (state == IDLE) && start_final_addition;
    assign last   = (cnt == CW'(NUM_DIGITS - 1));
    assign busy   = (state != IDLE);

    assign sum_d = {1'b0, s0_q[DIGIT_WIDTH-1:0]}
                 + {1'b0, s1_q[DIGIT_WIDTH-1:0]}
                 + {{DIGIT_WIDTH{1'b0}}, carry};

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start_final_addition) state_nx = ADD;
            ADD:     if (last) state_nx = SEL;
            SEL:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else if (ce) state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            s0_q  <= '0;
            s1_q  <= '0;
            sum_q <= '0;
            carry <= 1'b0;
            m     <= '0;
            cout  <= 1'b0;
            done  <= 1'b0;
        end else if (ce) begin
            done <= (state == SEL);
            if (accept) begin
                s0_q  <= s0_r;
                s1_q  <= s1_r;
                cnt   <= '0;
                carry <= 1'b0;
            end else if (state == ADD) begin
                s0_q  <= s0_q >> DIGIT_WIDTH;
                s1_q  <= s1_q >> DIGIT_WIDTH;
                sum_q <= {sum_d[DIGIT_WIDTH-1:0], sum_q[DATA_WIDTH-1:DIGIT_WIDTH]};
                carry <= sum_d[DIGIT_WIDTH];
                cnt   <= cnt + CW'(1);
            end else if (state == SEL) begin
                m    <= result;
                cout <= carry;
            end
        end
    end

`ifdef FINAL_ADDER_REDUCE_EN
    logic [DATA_WIDTH-1:0] n_q, diff_q;
    logic                  borrow;
    logic [DIGIT_WIDTH:0]  diff_d;

    assign diff_d = {1'b0, sum_d[DIGIT_WIDTH-1:0]}
                  - {1'b0, n_q[DIGIT_WIDTH-1:0]}
                  - {{DIGIT_WIDTH{1'b0}}, borrow};

    // A carry out means the full sum exceeds any DATA_WIDTH-bit modulus.
    assign result = (carry | ~borrow) ? diff_q : sum_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_q    <= '0;
            diff_q <= '0;
            borrow <= 1'b0;
        end else if (ce) begin
            if (accept) begin
                n_q    <= n;
                borrow <= 1'b0;
            end else if (state == ADD) begin
                n_q    <= n_q >> DIGIT_WIDTH;
                diff_q <= {diff_d[DIGIT_WIDTH-1:0], diff_q[DATA_WIDTH-1:DIGIT_WIDTH]};
                borrow <= diff_d[DIGIT_WIDTH];
            end
        end
    end
`else
    logic unused_n;
    assign unused_n = ^n;
    assign result   = sum_q;
`endif

endmodule

// File: tb/tb_final_adder_ms.sv
// Directed bench for final_adder_ms at DATA_WIDTH=6, DIGIT_WIDTH=2.
// Expected values follow the FINAL_ADDER_REDUCE_EN setting of the build.
module tb_final_adder_ms;

    localparam int DW = 6;

`ifdef FINAL_ADDER_REDUCE_EN
    localparam int EXP_A  = 13;
    localparam int EXP_B  = 40;
    localparam int EXP_BB = 10;
`else
    localparam int EXP_A  = 63;
    localparam int EXP_B  = 26;
    localparam int EXP_BB = 40;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ce = 1'b1;
    logic          start_final_addition = 1'b0;
    logic [DW-1:0] s0_r = '0;
    logic [DW-1:0] s1_r = '0;
    logic [DW-1:0] n = '0;
    logic          busy, done, cout;
    logic [DW-1:0] m;

    int checks = 0;
    int errors = 0;
    int lat;
    int nd;

    final_adder_ms #(.DATA_WIDTH(DW), .DIGIT_WIDTH(2)) dut (
        .clk(clk),
        .rst(rst),
        .ce(ce),
        .start_final_addition(start_final_addition),
        .s0_r(s0_r),
        .s1_r(s1_r),
        .n(n),
        .busy(busy),
        .done(done),
        .m(m),
        .cout(cout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic launch(input int a, input int b, input int nn);
        s0_r = DW'(a);
        s1_r = DW'(b);
        n    = DW'(nn);
        start_final_addition = 1'b1;
        tick();
        start_final_addition = 1'b0;
        s0_r = '1;
        s1_r = '1;
        n    = '1;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 20) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_m", int'(m), 0);
        chk("rst_cout", int'(cout), 0);
        rst = 1'b1;
        tick();

        launch(42, 21, 50);
        chk("busy_after_start", int'(busy), 1);
        wait_done(lat);
        chk("lat_a", lat, 4);
        chk("m_a", int'(m), EXP_A);
        chk("cout_a", int'(cout), 0);
        chk("busy_at_done", int'(busy), 0);

        launch(42, 21, 0);
        wait_done(lat);
        chk("lat_n0", lat, 4);
        chk("m_n0", int'(m), 63);

        launch(60, 30, 50);
        wait_done(lat);
        chk("lat_ovf", lat, 4);
        chk("m_ovf", int'(m), EXP_B);
        chk("cout_ovf", int'(cout), 1);

        launch(42, 21, 50);
        tick();
        tick();
        ce = 1'b0;
        tick();
        tick();
        tick();
        chk("busy_ce_low", int'(busy), 1);
        chk("done_ce_low", int'(done), 0);
        ce = 1'b1;
        wait_done(lat);
        chk("lat_ce", lat + 5, 7);
        chk("m_ce", int'(m), EXP_A);
        ce = 1'b0;
        tick();
        chk("done_hold_ce", int'(done), 1);
        ce = 1'b1;
        tick();
        chk("done_pulse_clear", int'(done), 0);

        launch(60, 30, 50);
        tick();
        s0_r = 6'd1;
        s1_r = 6'd1;
        n    = 6'd0;
        start_final_addition = 1'b1;
        tick();
        start_final_addition = 1'b0;
        wait_done(lat);
        chk("lat_ignore", lat + 2, 4);
        chk("m_ignore", int'(m), EXP_B);
        nd = 0;
        repeat (8) begin
            tick();
            if (done) nd++;
        end
        chk("single_done", nd, 0);

        launch(60, 30, 50);
        tick();
        rst = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_m", int'(m), 0);
        chk("arst_cout", int'(cout), 0);
        #2;
        rst = 1'b1;
        nd = 0;
        repeat (8) begin
            tick();
            if (done) nd++;
        end
        chk("no_done_after_rst", nd, 0);
        launch(42, 21, 50);
        wait_done(lat);
        chk("lat_post_rst", lat, 4);
        chk("m_post_rst", int'(m), EXP_A);

        launch(20, 20, 30);
        wait_done(lat);
        chk("lat_b2b", lat, 4);
        chk("m_b2b", int'(m), EXP_BB);
        chk("cout_b2b", int'(cout), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/final_adder_ms.md
# final_adder_ms

Digit-serial, parametrised final adder for the RSA modular-multiplication datapath. It resolves the carry-save pair (s0_r, s1_r) into a binary result, DIGIT_WIDTH bits per clock, and optionally applies the final conditional subtraction of the modulus n. It sits between the carry-save Montgomery core and the result register and exponentiation controller. It replaces the single-width final adder with a width/digit-generic, handshaked, reducing version.

## Interface
- DATA_WIDTH, default 32: operand/result width in bits.
- DIGIT_WIDTH, default 8: bits resolved per cycle. DATA_WIDTH % DIGIT_WIDTH != 0 is an elaboration error ($error).
- NUM_DIGITS (localparam) = DATA_WIDTH/DIGIT_WIDTH.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately).
- ce  in  1  clock enable; when 0 all state holds, including done.
- start_final_addition  in  1  start request, sampled on edges with ce=1.
- s0_r  in  DATA_WIDTH  carry-save sum vector; captured at accepted start.
- s1_r  in  DATA_WIDTH  carry-save carry vector; captured at accepted start.
- n  in  DATA_WIDTH  modulus; captured at accepted start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: m is valid.
- m  out  DATA_WIDTH  result; holds until the next done.
- cout  out  1  carry out of s0_r+s1_r, valid with done.

## Operation
- States: IDLE, ADD, SEL.
- IDLE: when start_final_addition=1 and ce=1, capture s0_r, s1_r and n into shift registers. Then: digit counter=0, sum carry=0, borrow=0, busy=1, go to ADD.
- ADD: each enabled cycle processes the least-significant unprocessed digit.
  - sum_d = s0_d + s1_d + carry, giving DIGIT_WIDTH+1 bits.
  - diff_d = sum_d[DIGIT_WIDTH-1:0] - n_d - borrow, giving the next borrow.
  - Shift both digits into the sum and diff registers from the MSB end.
  - After digit NUM_DIGITS-1, go to SEL.
- SEL: cout = final carry.
  - Reduction compiled in: m = (carry | ~borrow) ? diff : sum, i.e. full sum >= n selects diff.
  - Then done=1, busy=0, go to IDLE.
- Precondition (caller's duty): s0_r+s1_r < 2·n, so m < n. If violated, m = (sum-n) mod 2^DATA_WIDTH when sum >= n, else m = sum. No error is flagged.
- start while busy=1: ignored, with no effect on the operation in flight.
- start in the cycle done=1: accepted (state is IDLE).
- Inputs s0_r, s1_r and n may change freely after the accepting edge.
- Reset values: busy=0, done=0, m=0, cout=0, state=IDLE, counter=0, internal registers 0.
- Reset mid-operation: the operation is aborted immediately. No done is produced.

## Timing
- Edge E0 (start accepted) → busy=1 after E0.
- Edges E1..E(NUM_DIGITS) process digits 0..NUM_DIGITS-1.
- Edge E(NUM_DIGITS+1): m and cout update, done=1, busy=0.
- Latency: NUM_DIGITS+1 enabled cycles from start to done. Back-to-back throughput: one result every NUM_DIGITS+2 cycles.
- done lasts exactly one enabled cycle. It clears on the next edge with ce=1.
- ce=0 cycles stretch latency one-for-one. Nothing advances.
- Combinational depth: one DIGIT_WIDTH+1 adder plus one DIGIT_WIDTH subtractor per cycle.

## Configuration
- FINAL_ADDER_REDUCE_EN defined: the diff path, borrow chain and SEL mux are built. m is the reduced result.
- Not defined: no diff or borrow logic. n is unused (left unconnected internally). m = (s0_r+s1_r) mod 2^DATA_WIDTH and cout carries the overflow. Latency is unchanged.

## Test plan
All scenarios use DATA_WIDTH=6, DIGIT_WIDTH=2, ce=1 unless noted.
- s0_r=6'b101010, s1_r=6'b010101, n=50, macro on → done 4 cycles after start edge, m=13, cout=0. With n=0 → m=63.
- s0_r=60, s1_r=30, n=50, macro on → sum 90 overflows, m=40, cout=1.
- Same as the previous case with the macro off → m=26, cout=1. With s0_r=42, s1_r=21, n=50 → m=63.
- ce low for 3 cycles mid-ADD → done delayed exactly 3 cycles, m unchanged (13 for the first case). start pulsed while busy → ignored, only one done.
- rst=0 asserted during ADD → busy, done, m and cout go to 0 immediately. No done follows. A new start after release gives the correct m.
- Back-to-back: second start in the done cycle with s0_r=20, s1_r=20, n=30 → second done 4 cycles later, m=10.
